pipelined_adder_tree: RTL



---
 rtl/adder_tree_pkg.sv | 22 ++
 rtl/adder_tree_level.sv | 60 ++++++
 rtl/pipelined_adder_tree.sv | 124 ++++++++++++
 3 files changed

// File: rtl/adder_tree_pkg.sv
// Shared types and helpers for the pipelined adder tree.
// Optional accumulation is enabled with ADDER_TREE_ACC_EN.
package adder_tree_pkg;

    localparam int ACC_EXT_W_DEF = 8;

    // Per-beat sideband carried alongside the partial sums.
    typedef struct packed {
        logic valid;
        logic last;
    } side_t;

    function automatic int num_levels(input int n);
        return $clog2(n);
    endfunction

    // ceil(n / 2^k): partial count held by level k.
    function automatic int lanes_at(input int n, input int k);
        return (n + (1 << k) - 1) >> k;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: pairs of partials are summed.
// Ports: clk, rst_n, en, in_p/in_side (IN_LANES x IN_W), out_p/out_side.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int IN_LANES = 5,
    parameter int IN_W     = 16,
    parameter int SIGNED   = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    en,
    input  logic [IN_LANES*IN_W-1:0]                in_p,
    input  side_t                                   in_side,
    output logic [((IN_LANES+1)/2)*(IN_W+1)-1:0]    out_p,
    output side_t                                   out_side
);

    localparam int OUT_LANES = (IN_LANES + 1) / 2;
    localparam int OW        = IN_W + 1;

    logic [OUT_LANES*OW-1:0] sum_d;

    for (genvar j = 0; j < OUT_LANES; j++) begin : g_add
        logic [IN_W-1:0] a;
        logic [IN_W-1:0] b;
        logic [OW-1:0]   ax;
        logic [OW-1:0]   bx;

        assign a = in_p[2*j*IN_W +: IN_W];

        // An odd leftover partial is paired with a zero operand.
        if (2*j + 1 < IN_LANES) begin : g_pair
            assign b = in_p[(2*j+1)*IN_W +: IN_W];
        end else begin : g_odd
            assign b = '0;
        end

        if (SIGNED != 0) begin : g_sx
            assign ax = {a[IN_W-1], a};
            assign bx = {b[IN_W-1], b};
        end else begin : g_zx
            assign ax = {1'b0, a};
            assign bx = {1'b0, b};
        end

        assign sum_d[j*OW +: OW] = ax + bx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p    <= '0;
            out_side <= '0;
        end else if (en) begin
            out_p    <= sum_d;
            out_side <= in_side;
        end
    end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Fully pipelined NUM_IN-operand adder tree with global-advance flow control.
// Ports: in_data/in_valid/in_ready in, out_sum/out_valid/out_ready out.
// Define ADDER_TREE_ACC_EN to add in_last and a packet accumulator stage.
module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter int NUM_IN    = 5,
    parameter int DATA_W    = 16,
    parameter int SIGNED    = 0,
`ifdef ADDER_TREE_ACC_EN
    parameter int ACC_EXT_W = ACC_EXT_W_DEF,
    localparam int SUM_W    = DATA_W + $clog2(NUM_IN),
    localparam int OUT_W    = SUM_W + ACC_EXT_W
`else
    localparam int SUM_W    = DATA_W + $clog2(NUM_IN),
    localparam int OUT_W    = SUM_W
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic                     in_valid,
`ifdef ADDER_TREE_ACC_EN
    input  logic                     in_last,
`endif
    output logic                     in_ready,
    output logic [OUT_W-1:0]         out_sum,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int LEVELS = num_levels(NUM_IN);

    logic             adv;
    side_t            head;
    logic [SUM_W-1:0] tree_sum;
    side_t            tree_side;

    // Whole pipeline moves as one: advance unless a result is stuck.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

`ifdef ADDER_TREE_ACC_EN
    assign head = '{valid: in_valid, last: in_valid & in_last};
`else
    assign head = '{valid: in_valid, last: 1'b0};
`endif

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int IL = lanes_at(NUM_IN, k);
        localparam int IW = DATA_W + k;
        localparam int OL = lanes_at(NUM_IN, k + 1);

        logic [IL*IW-1:0]     pin;
        side_t                sin;
        logic [OL*(IW+1)-1:0] pout;
        side_t                sout;

        if (k == 0) begin : g_head
            assign pin = in_data;
            assign sin = head;
        end else begin : g_link
            assign pin = g_lvl[k-1].pout;
            assign sin = g_lvl[k-1].sout;
        end

        adder_tree_level #(
            .IN_LANES (IL),
            .IN_W     (IW),
            .SIGNED   (SIGNED)
        ) u_level (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (adv),
            .in_p     (pin),
            .in_side  (sin),
            .out_p    (pout),
            .out_side (sout)
        );
    end

    assign tree_sum  = g_lvl[LEVELS-1].pout;
    assign tree_side = g_lvl[LEVELS-1].sout;

`ifdef ADDER_TREE_ACC_EN
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] tree_x;
    logic [OUT_W-1:0] total;

    if (SIGNED != 0) begin : g_acc_sx
        assign tree_x = {{ACC_EXT_W{tree_sum[SUM_W-1]}}, tree_sum};
    end else begin : g_acc_zx
        assign tree_x = {{ACC_EXT_W{1'b0}}, tree_sum};
    end

    assign total = acc + tree_x;

    // Packet total is published on the last beat; acc restarts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= tree_side.valid & tree_side.last;
            if (tree_side.valid) begin
                if (tree_side.last) begin
                    out_sum <= total;
                    acc     <= '0;
                end else begin
                    acc <= total;
                end
            end
        end
    end
`else
    logic unused_last;

    assign unused_last = tree_side.last;
    assign out_sum     = tree_sum;
    assign out_valid   = tree_side.valid;
`endif

endmodule
